// File: rtl/regfile_io_ext.sv
// Register file with hardwired-zero r0, optional write bypass, handshaked
// external producer channels with pending/overrun status, and monitor taps.
module regfile_io_ext #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_EXT    = 2,
  parameter int unsigned EXT_BASE   = 20,
  parameter int unsigned EXT_STRIDE = 2,
  parameter int unsigned MON_BASE   = 16,
  parameter int unsigned NUM_MON    = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                        clock,
  input  logic                        ctrl_reset,
  input  logic                        ctrl_writeEnable,
  input  logic [ADDR_W-1:0]           ctrl_writeReg,
  input  logic [DATA_W-1:0]           data_writeReg,
  input  logic [ADDR_W-1:0]           ctrl_readRegA,
  input  logic [ADDR_W-1:0]           ctrl_readRegB,
  output logic [DATA_W-1:0]           data_readRegA,
  output logic [DATA_W-1:0]           data_readRegB,
  input  logic [NUM_EXT-1:0]          ext_valid,
  input  logic [NUM_EXT*DATA_W-1:0]   ext_data,
  output logic [NUM_EXT-1:0]          ext_ready,
  output logic [NUM_EXT-1:0]          ext_pending,
  output logic [NUM_EXT-1:0]          ext_overrun,
  output logic [NUM_MON*DATA_W-1:0]   mon_data
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  // Channel index owning register r, or -1 if the register is CPU-only.
  function automatic int chan_of(input int unsigned r);
    chan_of = -1;
    for (int unsigned i = 0; i < NUM_EXT; i++)
      if (EXT_BASE + i*EXT_STRIDE == r) chan_of = int'(i);
  endfunction

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [NUM_EXT-1:0] cpu_hit;
  logic [NUM_EXT-1:0] xfer;
  logic               cpu_we;

  assign cpu_we    = ctrl_reset & ctrl_writeEnable;
  assign ext_ready = {NUM_EXT{ctrl_reset}} & ~cpu_hit;
  assign xfer      = ext_valid & ext_ready;

  if (NUM_EXT > 1 && EXT_STRIDE == 0) begin : g_bad_stride
    $error("regfile_io_ext: EXT_STRIDE=0 maps several channels to one register");
  end
  if (MON_BASE + NUM_MON > NUM_REGS) begin : g_bad_mon
    $error("regfile_io_ext: monitor window exceeds the register file");
  end

  for (genvar i = 0; i < NUM_EXT; i++) begin : g_ext
    localparam int unsigned ADDR = EXT_BASE + i*EXT_STRIDE;
    if (ADDR == 0 || ADDR >= NUM_REGS) begin : g_bad_map
      $error("regfile_io_ext: channel %0d maps to invalid register %0d", i, ADDR);
    end
    assign cpu_hit[i] = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(ADDR));
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    localparam int CH = chan_of(r);
    if (r == 0) begin : g_zero
      always_ff @(posedge clock)
        regs[r] <= '0;
    end else if (CH >= 0) begin : g_mapped
      // A CPU write to a mapped register deasserts ready, so the branches never both apply.
      always_ff @(posedge clock) begin
        if (!ctrl_reset)
          regs[r] <= '0;
        else if (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(r))
          regs[r] <= data_writeReg;
        else if (xfer[CH])
          regs[r] <= ext_data[CH*DATA_W +: DATA_W];
      end
    end else begin : g_plain
      always_ff @(posedge clock) begin
        if (!ctrl_reset)
          regs[r] <= '0;
        else if (ctrl_writeEnable && ctrl_writeReg == ADDR_W'(r))
          regs[r] <= data_writeReg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      ext_pending <= '0;
      ext_overrun <= '0;
    end else begin
      ext_pending <= (ext_pending | xfer) & ~cpu_hit;
      ext_overrun <= (ext_overrun | (xfer & ext_pending)) & ~cpu_hit;
    end
  end

  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    if (ctrl_readRegA == '0)
      data_readRegA = '0;
    else if (BYPASS != 0 && cpu_we && ctrl_writeReg == ctrl_readRegA)
      data_readRegA = data_writeReg;
  end

  always_comb begin
    data_readRegB = regs[ctrl_readRegB];
    if (ctrl_readRegB == '0)
      data_readRegB = '0;
    else if (BYPASS != 0 && cpu_we && ctrl_writeReg == ctrl_readRegB)
      data_readRegB = data_writeReg;
  end

  for (genvar k = 0; k < NUM_MON; k++) begin : g_mon
    assign mon_data[k*DATA_W +: DATA_W] = regs[MON_BASE + k];
  end

endmodule

// File: tb/tb_regfile_io_ext.sv
// Directed bench for regfile_io_ext: one bypassing and one non-bypassing
// instance share all inputs so same-cycle read behaviour can be compared.
module tb_regfile_io_ext;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [1:0]  ext_valid;
  logic [63:0] ext_data;

  logic [31:0] rda, rdb, rda_nb, rdb_nb;
  logic [1:0]  ready, pending, overrun;
  logic [1:0]  ready_nb, pending_nb, overrun_nb;
  logic [63:0] mon, mon_nb;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  regfile_io_ext #(.BYPASS(1)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(rda), .data_readRegB(rdb),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ready),
    .ext_pending(pending), .ext_overrun(overrun), .mon_data(mon)
  );

  regfile_io_ext #(.BYPASS(0)) dut_nb (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(rda_nb), .data_readRegB(rdb_nb),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ready_nb),
    .ext_pending(pending_nb), .ext_overrun(overrun_nb), .mon_data(mon_nb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0;
    data_writeReg = '0; ctrl_readRegA = '0; ctrl_readRegB = '0;
    ext_valid = '0; ext_data = '0;

    // Reset: two edges with reset low
    step(); step();
    ctrl_readRegA = 5'd5;
    settle();
    check("rst_readA_r5", rda, 0);
    check("rst_ready",    ready, 2'b00);
    check("rst_pending",  pending, 2'b00);
    check("rst_overrun",  overrun, 2'b00);
    check("rst_mon",      mon, 0);

    // Write r5 after reset release
    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
    settle();
    check("wr5_nb_before",  rda_nb, 0);
    check("wr5_byp_before", rda, 32'hDEADBEEF);
    check("wr5_readB_r0",   rdb, 0);
    step();
    ctrl_writeEnable = 1'b0;
    settle();
    check("wr5_after",    rda, 32'hDEADBEEF);
    check("wr5_nb_after", rda_nb, 32'hDEADBEEF);
    check("wr5_r0_after", rdb, 0);

    // Writes to r0 are discarded and never bypassed
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
    ctrl_readRegA = 5'd0;
    settle();
    check("r0_byp_during", rda, 0);
    step();
    ctrl_writeEnable = 1'b0;
    settle();
    check("r0_after", rda, 0);

    // Bypass on both ports, same address
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'hA5A5A5A5;
    ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd7;
    settle();
    check("byp_A",    rda, 32'hA5A5A5A5);
    check("byp_B",    rdb, 32'hA5A5A5A5);
    check("nobyp_A",  rda_nb, 0);
    check("nobyp_B",  rdb_nb, 0);
    step();
    ctrl_writeEnable = 1'b0;
    settle();
    check("r7_nb_after", rdb_nb, 32'hA5A5A5A5);

    // Monitor taps show registered values only
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd16; data_writeReg = 32'h10;
    settle();
    check("mon_during_r16", mon, 0);
    step();
    ctrl_writeReg = 5'd17; data_writeReg = 32'h20;
    settle();
    check("mon_during_r17", mon, {32'h0, 32'h10});
    step();
    ctrl_writeEnable = 1'b0;
    settle();
    check("mon_after", mon, {32'h20, 32'h10});

    // Handshake on channel 0 (r20)
    ext_valid = 2'b01; ext_data = {32'h0, 32'h1};
    ctrl_readRegA = 5'd20;
    settle();
    check("hs_ready", ready, 2'b11);
    check("hs_no_bypass", rda, 0);
    step();
    ext_valid = 2'b00;
    settle();
    check("hs_r20_1",    rda, 32'h1);
    check("hs_pending1", pending, 2'b01);
    check("hs_overrun1", overrun, 2'b00);
    ext_valid = 2'b01; ext_data = {32'h0, 32'h2};
    step();
    ext_valid = 2'b00;
    settle();
    check("hs_r20_2",    rda, 32'h2);
    check("hs_pending2", pending, 2'b01);
    check("hs_overrun2", overrun, 2'b01);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd20; data_writeReg = 32'h0;
    settle();
    check("ack_ready", ready, 2'b10);
    step();
    ctrl_writeEnable = 1'b0;
    settle();
    check("ack_r20",     rda, 0);
    check("ack_pending", pending, 2'b00);
    check("ack_overrun", overrun, 2'b00);

    // Collision on channel 1 (r22): CPU wins, producer retries
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd22; data_writeReg = 32'h55;
    ext_valid = 2'b10; ext_data = {32'h77, 32'h0};
    ctrl_readRegA = 5'd22;
    settle();
    check("col_ready", ready, 2'b01);
    step();
    ctrl_writeEnable = 1'b0;
    settle();
    check("col_r22_cpu",   rda, 32'h55);
    check("col_ready_now", ready, 2'b11);
    check("col_pending0",  pending, 2'b00);
    step();
    ext_valid = 2'b00;
    settle();
    check("col_r22_ext",  rda, 32'h77);
    check("col_pending1", pending, 2'b10);

    // Both channels in one cycle; channel 1 already pending -> overrun
    ext_valid = 2'b11; ext_data = {32'hBBBB, 32'hAAAA};
    ctrl_readRegA = 5'd20; ctrl_readRegB = 5'd22;
    step();
    ext_valid = 2'b00;
    settle();
    check("dual_r20",     rda, 32'hAAAA);
    check("dual_r22",     rdb, 32'hBBBB);
    check("dual_pending", pending, 2'b11);
    check("dual_overrun", overrun, 2'b10);

    // Reset mid-handshake drops the transfer; it completes after release
    ctrl_reset = 1'b0;
    ext_valid = 2'b01; ext_data = {32'h0, 32'h66};
    settle();
    check("rmh_ready", ready, 2'b00);
    step();
    settle();
    check("rmh_r20",     rda, 0);
    check("rmh_pending", pending, 2'b00);
    check("rmh_overrun", overrun, 2'b00);
    step();
    check("rmh_r20_hold", rda, 0);
    ctrl_reset = 1'b1;
    settle();
    check("rmh_ready_rel", ready, 2'b11);
    step();
    ext_valid = 2'b00;
    settle();
    check("rmh_r20_done",  rda, 32'h66);
    check("rmh_pending_d", pending, 2'b01);
    check("rmh_overrun_d", overrun, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/regfile_io_ext.md
Name: regfile_io_ext

Overview:
- Parametrised successor to the processor register file: N x DATA_W registers, one CPU write port, two combinational read ports.
- Register 0 is hardwired to zero.
- Optional write-to-read bypass.
- NUM_EXT external-producer channels (button/screen style) write mapped registers through a valid/ready handshake, with per-channel pending and overrun status.
- NUM_MON monitor taps expose a contiguous register window to the game/VGA logic.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W.
- NUM_EXT, 2, number of external write channels.
- EXT_BASE, 20, register mapped to channel 0.
- EXT_STRIDE, 2, register spacing between channels; channel i maps to EXT_BASE + i*EXT_STRIDE.
- MON_BASE, 16, first monitored register.
- NUM_MON, 2, number of monitored registers.
- BYPASS, 1, 1 = a same-cycle CPU write is forwarded to the read ports.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- ctrl_reset  in  1  synchronous, active-low reset.
- ctrl_writeEnable  in  1  CPU write strobe.
- ctrl_writeReg  in  ADDR_W  CPU write address.
- data_writeReg  in  DATA_W  CPU write data.
- ctrl_readRegA  in  ADDR_W  read address, port A.
- ctrl_readRegB  in  ADDR_W  read address, port B.
- data_readRegA  out  DATA_W  read data, port A (combinational).
- data_readRegB  out  DATA_W  read data, port B (combinational).
- ext_valid  in  NUM_EXT  per-channel write request.
- ext_data  in  NUM_EXT*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- ext_ready  out  NUM_EXT  per-channel accept (combinational).
- ext_pending  out  NUM_EXT  sticky: channel wrote data that the CPU has not yet acknowledged.
- ext_overrun  out  NUM_EXT  sticky: a channel write landed while pending was already set.
- mon_data  out  NUM_MON*DATA_W  contents of registers MON_BASE..MON_BASE+NUM_MON-1.

Behaviour:
- Reset:
  - ctrl_reset=0 at a rising edge clears all registers, ext_pending and ext_overrun to 0.
  - While ctrl_reset=0: ext_ready=0 and CPU writes are ignored.
  - Reads stay combinational; they return 0 after the first reset edge.
  - Reset asserted mid-handshake drops the pending transfer; the producer must re-present it.
- Register 0:
  - Reads always return 0; writes to address 0 (CPU or mapping) have no effect.
  - Elaboration fails if any channel maps to 0 or to an address >= NUM_REGS.
- CPU write: ctrl_writeEnable=1 with ctrl_reset=1 → register[ctrl_writeReg] <= data_writeReg at the edge.
- Reads:
  - data_readRegX = register[ctrl_readRegX].
  - If BYPASS=1, ctrl_writeEnable=1, ctrl_writeReg == ctrl_readRegX and the address is non-zero, the read returns data_writeReg in the same cycle.
  - Both ports may read the same address.
- External channel i (address Ai):
  - ext_ready[i] = ctrl_reset & ~(ctrl_writeEnable & ctrl_writeWriteReg_is_Ai), i.e. ready unless the CPU is writing Ai this cycle.
  - Transfer occurs when ext_valid[i] & ext_ready[i]; register[Ai] <= ext_data[i] at the edge. Latency 1: readable the next cycle, not bypassed.
  - Collision rule: the CPU wins; the producer holds valid and data until ready.
- Status flags, channel i:
  - ext_pending[i] set on transfer; cleared on a CPU write to Ai (software acknowledge).
  - Set and clear cannot coincide, because the collision rule blocks the transfer.
  - ext_overrun[i] set on a transfer while ext_pending[i]=1; cleared only by a CPU write to Ai or by reset.
- Monitor taps: mon_data slice k = register[MON_BASE+k], registered value only (no bypass).
- Channels are independent: simultaneous transfers on all channels in one cycle are all accepted.

Test Plan:
1. Reset then write, default params: hold ctrl_reset=0 for 2 cycles, then write 0xDEADBEEF to r5 → readA(r5)=0 before the edge and 0xDEADBEEF after it; readB(r0)=0 throughout; write 0x1234 to r0 → readA(r0) stays 0.
2. Bypass: same cycle, write r7=0xA5A5A5A5 with readA=r7 and readB=r7 → both ports return 0xA5A5A5A5 in that cycle; with BYPASS=0 both return the old value 0.
3. Handshake: ext_valid[0]=1, data=0x1 → ext_ready[0]=1; next cycle readA(r20)=0x1 and ext_pending[0]=1. A second transfer of 0x2 → r20=0x2 and ext_overrun[0]=1. CPU write r20=0 → pending=0 and overrun=0.
4. Collision: CPU writes r22=0x55 while ext_valid[1]=1 with 0x77 → ext_ready[1]=0 and r22=0x55. Next cycle ext accepted → r22=0x77, pending[1]=1.
5. Monitor taps: write r16=0x10 and r17=0x20 → mon_data={0x20,0x10} one cycle later, not during the write cycle.
6. Reset mid-handshake: ext_valid[0]=1 with ctrl_reset=0 → ext_ready[0]=0, r20 stays 0, no flags set. Release reset → transfer completes on the next edge.
